// File: rtl/demux_pkg.sv
// Shared widths, beat/select types and slot state encoding for the registered 1:N demux.
package demux_pkg;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = $clog2(NUM_CH);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  sel_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_ch_slot.sv
// One output channel: a single-entry data register plus its EMPTY/FULL valid state.
module demux_ch_slot
  import demux_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
  input  logic          drain_rdy,
  input  logic [DW-1:0] din,
  output logic          valid,
  output logic [DW-1:0] dout
);

  slot_state_t state;

  // A drain in the same cycle as a fill keeps the slot full with the new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      dout  <= '0;
    end else begin
      if (fill)
        dout <= din;
      case (state)
        SLOT_EMPTY: if (fill) state <= SLOT_FULL;
        SLOT_FULL:  if (drain_rdy && !fill) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1to8_reg.sv
// Registered 1:N demultiplexer with per-channel one-entry slots.
// Optional round-robin destination mode is enabled by defining DEMUX_AUTOSEL_EN.
module demux_1to8_reg #(
  parameter  int DATA_W = demux_pkg::DATA_W,
  parameter  int NUM_CH = demux_pkg::NUM_CH,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data
`ifdef DEMUX_AUTOSEL_EN
  ,
  input  logic                     auto_sel
`endif
);

  logic [SEL_W-1:0]  dest;
  logic              accept;
  logic [NUM_CH-1:0] fill;

`ifdef DEMUX_AUTOSEL_EN
  logic [SEL_W-1:0] rr_cnt;

  // NUM_CH is a power of two, so the natural SEL_W-bit overflow is the wrap to 0.
  always_ff @(posedge clk) begin
    if (rst)
      rr_cnt <= '0;
    else if (accept && auto_sel)
      rr_cnt <= rr_cnt + 1'b1;
  end

  assign dest = auto_sel ? rr_cnt : sel;
`else
  assign dest = sel;
`endif

  // Ready only looks at the addressed slot, so a stalled channel never blocks the others.
  assign in_ready = ~out_valid[dest] | out_ready[dest];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign fill[k] = accept && (dest == SEL_W'(k));

    demux_ch_slot #(
      .DW(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .fill     (fill[k]),
      .drain_rdy(out_ready[k]),
      .din      (in_data),
      .valid    (out_valid[k]),
      .dout     (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux_1to8_reg.sv
// Self-checking bench for demux_1to8_reg: directed scenarios followed by random traffic
// against a queue-based channel model. Covers round-robin mode when DEMUX_AUTOSEL_EN is defined.
module tb_demux_1to8_reg;
  import demux_pkg::*;

  localparam int NCH = NUM_CH;
  localparam int DW  = DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  data_t             in_data;
  sel_t              sel;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*DW-1:0] out_data;
`ifdef DEMUX_AUTOSEL_EN
  logic              auto_sel;
`endif

  demux_1to8_reg dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef DEMUX_AUTOSEL_EN
    ,
    .auto_sel (auto_sel)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each channel is a FIFO of accepted beats (capacity one),
  // and the visible data is whatever was last accepted into that channel.
  data_t q[NCH][$];
  data_t lastData[NCH];
  int    rrCnt;
  bit    autoMode;
  logic  sampledReady;

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int modelDest(input sel_t s);
    return autoMode ? rrCnt : int'(s);
  endfunction

  task automatic checkOutput(input sel_t s);
    logic [NCH-1:0]    expValid;
    logic [NCH*DW-1:0] expData;
    int                d;
    d = modelDest(s);
    for (int k = 0; k < NCH; k++) begin
      expValid[k]          = (q[k].size() != 0);
      expData[k*DW +: DW]  = lastData[k];
    end
    checkValue("in_ready",  64'(in_ready),  64'((q[d].size() == 0) || out_ready[d]));
    checkValue("out_valid", 64'(out_valid), 64'(expValid));
    checkValue("out_data",  64'(out_data),  64'(expData));
  endtask

  task automatic updateModel(input bit r, input bit v, input sel_t s, input data_t dat,
                             input logic [NCH-1:0] ordy);
    int d;
    bit acc;
    if (r) begin
      for (int k = 0; k < NCH; k++) begin
        q[k].delete();
        lastData[k] = '0;
      end
      rrCnt = 0;
    end else begin
      d   = modelDest(s);
      acc = v && ((q[d].size() == 0) || ordy[d]);
      for (int k = 0; k < NCH; k++)
        if (q[k].size() != 0 && ordy[k])
          void'(q[k].pop_front());
      if (acc) begin
        q[d].push_back(dat);
        lastData[d] = dat;
        if (autoMode)
          rrCnt = (rrCnt + 1) % NCH;
      end
    end
  endtask

  // Drive one cycle of inputs after the falling edge, check outputs, then advance the model.
  task automatic applyStimulus(input bit r, input bit v, input sel_t s, input data_t dat,
                               input logic [NCH-1:0] ordy, input bit doCheck);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    sel       = s;
    in_data   = dat;
    out_ready = ordy;
`ifdef DEMUX_AUTOSEL_EN
    auto_sel  = autoMode;
`endif
    #1;
    sampledReady = in_ready;
    if (doCheck)
      checkOutput(s);
    @(posedge clk);
    updateModel(r, v, s, dat, ordy);
    #2;
  endtask

  function automatic data_t chData(input int k);
    return out_data[k*DW +: DW];
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    data_t seqBytes[8];
    seqBytes = '{8'h34, 8'h12, 8'h45, 8'hA3, 8'h3D, 8'hFF, 8'h67, 8'h93};
    autoMode = 1'b0;
    rrCnt    = 0;
    for (int k = 0; k < NCH; k++) lastData[k] = '0;
    rst = 1'b1; in_valid = 1'b0; sel = '0; in_data = '0; out_ready = '0;
`ifdef DEMUX_AUTOSEL_EN
    auto_sel = 1'b0;
`endif

    $display("[TB] reset with in_valid held high");
    applyStimulus(1, 1, 3'd0, 8'hAA, 8'hFF, 0);
    applyStimulus(1, 1, 3'd3, 8'h55, 8'hFF, 1);
    checkValue("reset_out_valid", 64'(out_valid), 64'h0);
    checkValue("reset_out_data",  64'(out_data),  64'h0);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF, 1);

    $display("[TB] sequential fill of all channels");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, sel_t'(k), seqBytes[k], 8'hFF, 1);
      checkValue("seq_valid_bit", 64'(out_valid[k]), 64'h1);
    end
    applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF, 1);
    checkValue("seq_all_data",  64'(out_data),  64'h9367FF3DA3451234);
    checkValue("seq_all_empty", 64'(out_valid), 64'h0);

    $display("[TB] backpressure on channel 2");
    applyStimulus(0, 1, 3'd2, 8'h45, 8'hFB, 1);
    checkValue("bp_first_ready", 64'(sampledReady), 64'h1);
    checkValue("bp_ch2_data",    64'(chData(2)),    64'h45);
    applyStimulus(0, 1, 3'd2, 8'hA3, 8'hFB, 1);
    checkValue("bp_stall_ready", 64'(sampledReady), 64'h0);
    applyStimulus(0, 1, 3'd2, 8'hA3, 8'hFB, 1);
    checkValue("bp_stall_hold",  64'(chData(2)),    64'h45);
    applyStimulus(0, 1, 3'd2, 8'hA3, 8'hFF, 1);
    checkValue("bp_release_ready", 64'(sampledReady), 64'h1);
    checkValue("bp_second_data",   64'(chData(2)),    64'hA3);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF, 1);

    $display("[TB] cross-channel stall isolation");
    applyStimulus(0, 1, 3'd2, 8'h45, 8'hFB, 1);
    applyStimulus(0, 1, 3'd4, 8'h3D, 8'hFB, 1);
    checkValue("iso_ready",   64'(sampledReady), 64'h1);
    checkValue("iso_ch4",     64'(chData(4)),    64'h3D);
    checkValue("iso_ch2",     64'(chData(2)),    64'h45);

    $display("[TB] same-cycle drain and fill on channel 5");
    applyStimulus(0, 1, 3'd5, 8'hFF, 8'hDB, 1);
    checkValue("df_ch5_first", 64'(chData(5)), 64'hFF);
    applyStimulus(0, 1, 3'd5, 8'h67, 8'hFB, 1);
    checkValue("df_ready",   64'(sampledReady),  64'h1);
    checkValue("df_valid",   64'(out_valid[5]),  64'h1);
    checkValue("df_ch5_new", 64'(chData(5)),     64'h67);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF, 1);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF, 1);

`ifdef DEMUX_AUTOSEL_EN
    $display("[TB] round-robin destination with wrap and reset");
    applyStimulus(1, 0, 3'd0, 8'h00, 8'hFF, 1);
    autoMode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 3'd3, data_t'(8'h10 + i), 8'hFF, 1);
      checkValue("rr_landing", 64'(chData(i % 8)), 64'(8'h10 + i));
    end
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 3'd3, data_t'(8'h20 + i), 8'hFF, 1);
    applyStimulus(1, 1, 3'd3, 8'hEE, 8'hFF, 1);
    applyStimulus(0, 1, 3'd3, 8'hC5, 8'hFF, 1);
    checkValue("rr_after_reset", 64'(chData(0)), 64'hC5);
    checkValue("rr_after_reset_valid", 64'(out_valid), 64'h1);
    autoMode = 1'b0;
    applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF, 1);
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 500; n++) begin
`ifdef DEMUX_AUTOSEL_EN
      autoMode = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    sel_t'($urandom_range(0, NCH - 1)),
                    data_t'($urandom),
                    (NCH)'($urandom | $urandom),
                    1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
